mult_pipe_gen: RTL and testbench
================================

Name: mult_pipe_gen

Overview:
Parametrised, stall-capable pipelined integer multiplier for the execute stage. It supports all four RV M-extension multiply ops, returning the low or high XLEN bits of the 2*XLEN product. Each in-flight op is tracked per stage against branch-mask resolve/mispredict, and a full flush drops everything. An OUT_DEPTH-entry result queue sits between the last stage and the CDB, so a denied CDB grant does not immediately stall the pipe.

Parameters:
XLEN, 32, operand/result width
MULT_STAGES, 4, pipeline stages; (2*XLEN) % MULT_STAGES must be 0
TAG_W, 6, destination physical-register index width
BM_W, 4, branch-mask width
OUT_DEPTH, 2, result queue entries (>=1)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  new op offered
in_func  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
in_rs1  in  XLEN  multiplicand
in_rs2  in  XLEN  multiplier
in_tag  in  TAG_W  destination reg idx
in_bm  in  BM_W  branch mask of op
in_ready  out  1  op accepted this edge when in_valid & in_ready
b_resolve  in  BM_W  one-hot (or zero) resolving branch bit
b_mispred  in  1  resolving branch mispredicted
flush  in  1  kill all in-flight ops
cdb_grant  in  1  CDB accepts queue head this edge
out_valid  out  1  CDB request; queue head valid
out_result  out  XLEN  head result
out_tag  out  TAG_W  head tag
out_bm  out  BM_W  head mask, current resolve bits already cleared
busy  out  1  any stage or queue entry valid

Behaviour:
- Reset (async, reset_n=0): all stage/queue valids 0, queue pointers/count 0. Outputs: out_valid=0, busy=0, in_ready=1, out_result/out_tag/out_bm=0.
- Operand extension to 2*XLEN: rs1 sign-extended for MUL/MULH/MULHSU, else zero-extended. rs2 sign-extended for MUL/MULH, else zero-extended.
- Stage computation, SHIFT=2*XLEN/MULT_STAGES: sum += mplier[SHIFT-1:0]*mcand (mod 2^(2*XLEN)); mplier >>= SHIFT; mcand <<= SHIFT.
- Result selection: MUL takes sum[XLEN-1:0]; the other three take sum[2*XLEN-1:XLEN]. func is carried down the pipe.
- Advance rule: stage i loads from stage i-1 when stage i is empty or stage i itself advances. Bubbles collapse. The last stage advances when the queue is not full, or is full and popping this edge. in_ready equals the stage-0 advance condition (combinational chain, no registered ready).
- Latency: with no stalls, an op accepted at edge k is written to the queue at edge k+MULT_STAGES. out_valid is high in the following cycle if the queue was empty.
- Throughput: one op per cycle. With cdb_grant held low, exactly MULT_STAGES+OUT_DEPTH ops are accepted, then in_ready=0.
- Queue: in-order FIFO. Pop on out_valid & cdb_grant. An invalid (squashed) head with count>0 is popped automatically without a grant. Push and pop in the same edge are allowed when full.
- Branch resolve, applied to the input op, every stage and every queue entry, on the value being registered this edge:
  - If valid & (bm & b_resolve)!=0 and b_mispred=1: the entry becomes invalid.
  - If b_mispred=0: the resolved bits are cleared.
  - Combinational kill: if the head is squashed this cycle, out_valid=0 in that same cycle. out_bm shows the cleared mask on a correct resolve.
- flush=1: every stage and queue entry is invalidated at the edge, the queue count is reset, and any input offered that cycle is dropped. in_ready may be 1 but the op is discarded. flush dominates b_resolve and cdb_grant; out_valid=0 during flush.
- Simultaneous events: an accepted op whose in_bm hits the current mispredict is never entered. A pop, push and squash on the same edge are all applied, with count computed from post-squash validity.
- Reset mid-operation: all state is cleared immediately; no result emerges afterwards.

Test Plan:
- XLEN=32: MUL rs1=3, rs2=0xFFFFFFFB -> out_result=0xFFFFFFF1 exactly 4 cycles after acceptance, correct tag.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MUL same operands -> 0x00000001. MULH same -> 0x00000000. MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- cdb_grant=0, 8 back-to-back ops -> in_ready falls after the 6th acceptance. Then grant=1 -> 6 results emerge in order, one per cycle, and ops 7-8 are accepted as space frees.
- Ops A(bm=0001), B(bm=0010), C(bm=0011) in flight; b_resolve=0010, b_mispred=1 -> B and C never appear on the CDB; A completes with out_bm=0001. Repeat with b_mispred=0 -> B and C complete with out_bm=0000 and 0001.
- Queue head squashed while cdb_grant=1 -> out_valid=0 that cycle, the head is auto-popped, and the next entry is presented the following cycle.
- flush with 3 ops in flight plus one offered -> busy=0 next cycle, no outputs. reset_n pulsed low mid-operation -> out_valid=0 asynchronously, in_ready=1 after release.

Source files
------------

// File: rtl/mult_pipe_gen.sv
// Stall-capable pipelined RV M-extension multiplier with branch-mask tracking
// and a small in-order result queue in front of the CDB.
module mult_pipe_gen #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned MULT_STAGES = 4,
    parameter int unsigned TAG_W       = 6,
    parameter int unsigned BM_W        = 4,
    parameter int unsigned OUT_DEPTH   = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [1:0]       in_func,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [BM_W-1:0]  in_bm,
    output logic             in_ready,
    input  logic [BM_W-1:0]  b_resolve,
    input  logic             b_mispred,
    input  logic             flush,
    input  logic             cdb_grant,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [BM_W-1:0]  out_bm,
    output logic             busy
);

    localparam int unsigned PW    = 2 * XLEN;
    localparam int unsigned SHIFT = PW / MULT_STAGES;
    localparam int unsigned PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);

    // Pipeline stage state
    logic [MULT_STAGES-1:0] stg_valid;
    logic [1:0]             stg_func   [MULT_STAGES];
    logic [PW-1:0]          stg_sum    [MULT_STAGES];
    logic [PW-1:0]          stg_mcand  [MULT_STAGES];
    logic [PW-1:0]          stg_mplier [MULT_STAGES];
    logic [TAG_W-1:0]       stg_tag    [MULT_STAGES];
    logic [BM_W-1:0]        stg_bm     [MULT_STAGES];

    // Source of each stage: the input op for stage 0, otherwise the stage above
    logic [MULT_STAGES-1:0] src_valid;
    logic [1:0]             src_func   [MULT_STAGES];
    logic [PW-1:0]          src_sum    [MULT_STAGES];
    logic [PW-1:0]          src_mcand  [MULT_STAGES];
    logic [PW-1:0]          src_mplier [MULT_STAGES];
    logic [TAG_W-1:0]       src_tag    [MULT_STAGES];
    logic [BM_W-1:0]        src_bm     [MULT_STAGES];

    logic [MULT_STAGES-1:0] nx_valid;
    logic [1:0]             nx_func    [MULT_STAGES];
    logic [PW-1:0]          nx_sum     [MULT_STAGES];
    logic [PW-1:0]          nx_mcand   [MULT_STAGES];
    logic [PW-1:0]          nx_mplier  [MULT_STAGES];
    logic [TAG_W-1:0]       nx_tag     [MULT_STAGES];
    logic [BM_W-1:0]        nx_bm      [MULT_STAGES];

    // Result queue state
    logic [OUT_DEPTH-1:0]   q_valid;
    logic [XLEN-1:0]        q_res [OUT_DEPTH];
    logic [TAG_W-1:0]       q_tag [OUT_DEPTH];
    logic [BM_W-1:0]        q_bm  [OUT_DEPTH];
    logic [PTR_W-1:0]       q_head, q_tail;
    logic [CNT_W-1:0]       q_count;

    logic [OUT_DEPTH-1:0]   nq_valid;
    logic [XLEN-1:0]        nq_res [OUT_DEPTH];
    logic [TAG_W-1:0]       nq_tag [OUT_DEPTH];
    logic [BM_W-1:0]        nq_bm  [OUT_DEPTH];
    logic [PTR_W-1:0]       nq_head, nq_tail;
    logic [CNT_W-1:0]       nq_count;

    logic [MULT_STAGES-1:0] ld;
    logic [BM_W-1:0]        bm_clr;
    logic                   head_live;
    logic                   q_nonempty;
    logic                   pop;
    logic                   push;
    logic                   last_adv;
    logic [XLEN-1:0]        push_res;

    function automatic logic hit(input logic [BM_W-1:0] bm, input logic [BM_W-1:0] res,
                                 input logic mis);
        return mis & (|(bm & res));
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Queue pop/push decisions and the combinational advance chain back to in_ready
    always_comb begin
        logic chain;
        bm_clr     = b_mispred ? '0 : b_resolve;
        q_nonempty = (q_count != '0);
        head_live  = q_valid[q_head] & ~hit(q_bm[q_head], b_resolve, b_mispred);
        pop        = q_nonempty & (~head_live | cdb_grant);
        last_adv   = (q_count != CNT_W'(OUT_DEPTH)) | pop;
        push       = stg_valid[MULT_STAGES-1]
                   & ~hit(stg_bm[MULT_STAGES-1], b_resolve, b_mispred)
                   & last_adv & ~flush;
        push_res   = (stg_func[MULT_STAGES-1] == 2'b00) ? stg_sum[MULT_STAGES-1][XLEN-1:0]
                                                        : stg_sum[MULT_STAGES-1][PW-1:XLEN];
        ld    = '0;
        chain = last_adv;
        for (int i = MULT_STAGES - 1; i >= 0; i--) begin
            ld[i] = ~stg_valid[i] | chain;
            chain = ld[i];
        end
    end

    // Stage sources: extended operands for stage 0, previous stage otherwise
    always_comb begin
        src_valid[0]  = in_valid & ld[0];
        src_func[0]   = in_func;
        src_sum[0]    = '0;
        src_mcand[0]  = (in_func != 2'b11) ? {{XLEN{in_rs1[XLEN-1]}}, in_rs1}
                                           : {{XLEN{1'b0}}, in_rs1};
        src_mplier[0] = (in_func[1] == 1'b0) ? {{XLEN{in_rs2[XLEN-1]}}, in_rs2}
                                             : {{XLEN{1'b0}}, in_rs2};
        src_tag[0]    = in_tag;
        src_bm[0]     = in_bm;
        for (int i = 1; i < MULT_STAGES; i++) begin
            src_valid[i]  = stg_valid[i-1];
            src_func[i]   = stg_func[i-1];
            src_sum[i]    = stg_sum[i-1];
            src_mcand[i]  = stg_mcand[i-1];
            src_mplier[i] = stg_mplier[i-1];
            src_tag[i]    = stg_tag[i-1];
            src_bm[i]     = stg_bm[i-1];
        end
    end

    // Stage next state: one shift-add step on load, branch resolve on every entry
    always_comb begin
        logic [PW-1:0] chunk;
        chunk = '0;
        for (int i = 0; i < MULT_STAGES; i++) begin
            nx_valid[i]  = stg_valid[i] & ~hit(stg_bm[i], b_resolve, b_mispred);
            nx_func[i]   = stg_func[i];
            nx_sum[i]    = stg_sum[i];
            nx_mcand[i]  = stg_mcand[i];
            nx_mplier[i] = stg_mplier[i];
            nx_tag[i]    = stg_tag[i];
            nx_bm[i]     = stg_bm[i] & ~bm_clr;
            if (ld[i]) begin
                chunk        = PW'(src_mplier[i][SHIFT-1:0]);
                nx_valid[i]  = src_valid[i] & ~hit(src_bm[i], b_resolve, b_mispred);
                nx_func[i]   = src_func[i];
                nx_sum[i]    = src_sum[i] + src_mcand[i] * chunk;
                nx_mcand[i]  = src_mcand[i] << SHIFT;
                nx_mplier[i] = src_mplier[i] >> SHIFT;
                nx_tag[i]    = src_tag[i];
                nx_bm[i]     = src_bm[i] & ~bm_clr;
            end
        end
        if (flush) begin
            nx_valid = '0;
        end
    end

    // Queue next state: resolve all entries, then pop, then push, flush wins
    always_comb begin
        nq_head  = q_head;
        nq_tail  = q_tail;
        nq_count = q_count;
        for (int j = 0; j < OUT_DEPTH; j++) begin
            nq_valid[j] = q_valid[j] & ~hit(q_bm[j], b_resolve, b_mispred);
            nq_res[j]   = q_res[j];
            nq_tag[j]   = q_tag[j];
            nq_bm[j]    = q_bm[j] & ~bm_clr;
        end
        if (pop) begin
            nq_valid[q_head] = 1'b0;
            nq_head          = ptr_inc(q_head);
        end
        if (push) begin
            nq_valid[q_tail] = 1'b1;
            nq_res[q_tail]   = push_res;
            nq_tag[q_tail]   = stg_tag[MULT_STAGES-1];
            nq_bm[q_tail]    = stg_bm[MULT_STAGES-1] & ~bm_clr;
            nq_tail          = ptr_inc(q_tail);
        end
        if (push && !pop) begin
            nq_count = q_count + CNT_W'(1);
        end else if (pop && !push) begin
            nq_count = q_count - CNT_W'(1);
        end
        if (flush) begin
            nq_valid = '0;
            nq_head  = '0;
            nq_tail  = '0;
            nq_count = '0;
        end
    end

    // Pipeline stage registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stg_valid <= '0;
            for (int i = 0; i < MULT_STAGES; i++) begin
                stg_func[i]   <= '0;
                stg_sum[i]    <= '0;
                stg_mcand[i]  <= '0;
                stg_mplier[i] <= '0;
                stg_tag[i]    <= '0;
                stg_bm[i]     <= '0;
            end
        end else begin
            stg_valid <= nx_valid;
            for (int i = 0; i < MULT_STAGES; i++) begin
                stg_func[i]   <= nx_func[i];
                stg_sum[i]    <= nx_sum[i];
                stg_mcand[i]  <= nx_mcand[i];
                stg_mplier[i] <= nx_mplier[i];
                stg_tag[i]    <= nx_tag[i];
                stg_bm[i]     <= nx_bm[i];
            end
        end
    end

    // Result queue registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_valid <= '0;
            q_head  <= '0;
            q_tail  <= '0;
            q_count <= '0;
            for (int j = 0; j < OUT_DEPTH; j++) begin
                q_res[j] <= '0;
                q_tag[j] <= '0;
                q_bm[j]  <= '0;
            end
        end else begin
            q_valid <= nq_valid;
            q_head  <= nq_head;
            q_tail  <= nq_tail;
            q_count <= nq_count;
            for (int j = 0; j < OUT_DEPTH; j++) begin
                q_res[j] <= nq_res[j];
                q_tag[j] <= nq_tag[j];
                q_bm[j]  <= nq_bm[j];
            end
        end
    end

    assign in_ready   = ld[0];
    assign out_valid  = q_nonempty & head_live & ~flush;
    assign out_result = q_res[q_head];
    assign out_tag    = q_tag[q_head];
    assign out_bm     = q_bm[q_head] & ~bm_clr;
    assign busy       = (|stg_valid) | q_nonempty;

endmodule

// File: tb/tb_mult_pipe_gen.sv
// Directed bench for mult_pipe_gen: vector table plus multi-cycle corner sequences.
module tb_mult_pipe_gen;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic [1:0]  in_func;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [5:0]  in_tag;
    logic [3:0]  in_bm;
    logic        in_ready;
    logic [3:0]  b_resolve;
    logic        b_mispred;
    logic        flush;
    logic        cdb_grant;
    logic        out_valid;
    logic [31:0] out_result;
    logic [5:0]  out_tag;
    logic [3:0]  out_bm;
    logic        busy;

    int checks;
    int errors;

    logic [31:0] got_res[$];
    logic [5:0]  got_tag[$];
    logic [3:0]  got_bm[$];

    typedef struct {
        logic [1:0]  func;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    mult_pipe_gen #(
        .XLEN(32), .MULT_STAGES(4), .TAG_W(6), .BM_W(4), .OUT_DEPTH(2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_func    (in_func),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_tag     (in_tag),
        .in_bm      (in_bm),
        .in_ready   (in_ready),
        .b_resolve  (b_resolve),
        .b_mispred  (b_mispred),
        .flush      (flush),
        .cdb_grant  (cdb_grant),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_bm     (out_bm),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] t, input logic [3:0] m);
        in_valid = 1'b1;
        in_func  = f;
        in_rs1   = a;
        in_rs2   = b;
        in_tag   = t;
        in_bm    = m;
        #1;
        chk("issue_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic clear_got();
        got_res.delete();
        got_tag.delete();
        got_bm.delete();
    endtask

    task automatic collect(input int n);
        for (int c = 0; c < n; c++) begin
            #1;
            if (out_valid && cdb_grant) begin
                got_res.push_back(out_result);
                got_tag.push_back(out_tag);
                got_bm.push_back(out_bm);
            end
            tick();
        end
    endtask

    task automatic run_branch(input logic mis);
        logic [5:0]  et[4];
        logic [3:0]  eb[4];
        logic [31:0] er[4];
        int          n_exp;
        et = '{6'd20, 6'd21, 6'd22, 6'd23};
        eb = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
        er = '{32'd35, 32'd42, 32'd56, 32'd63};
        n_exp = mis ? 1 : 4;
        clear_got();
        cdb_grant = 1'b1;
        issue(2'b00, 32'd5, 32'd7, 6'd20, 4'b0001);
        issue(2'b00, 32'd6, 32'd7, 6'd21, 4'b0010);
        issue(2'b00, 32'd8, 32'd7, 6'd22, 4'b0011);
        b_resolve = 4'b0010;
        b_mispred = mis;
        issue(2'b00, 32'd9, 32'd7, 6'd23, 4'b0010);
        b_resolve = 4'b0000;
        b_mispred = 1'b0;
        collect(12);
        chk(mis ? "br_mis_count" : "br_ok_count", 64'(got_tag.size()), 64'(n_exp));
        for (int k = 0; k < n_exp && k < got_tag.size(); k++) begin
            chk("br_tag", 64'(got_tag[k]), 64'(et[k]));
            chk("br_bm", 64'(got_bm[k]), 64'(eb[k]));
            chk("br_res", 64'(got_res[k]), 64'(er[k]));
        end
    endtask

    initial begin : main
        logic [31:0] bp_a[8];
        logic [31:0] bp_b[8];
        logic [31:0] bp_exp[8];
        logic [31:0] exp_q[$];
        logic [63:0] prod;
        int          idx;
        int          pops;

        checks    = 0;
        errors    = 0;
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        in_func   = 2'b00;
        in_rs1    = '0;
        in_rs2    = '0;
        in_tag    = '0;
        in_bm     = '0;
        b_resolve = '0;
        b_mispred = 1'b0;
        flush     = 1'b0;
        cdb_grant = 1'b0;

        vecs[0]  = '{2'b00, 32'd3,         32'hFFFF_FFFB, 32'hFFFF_FFF1};
        vecs[1]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[3]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[4]  = '{2'b10, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
        vecs[5]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[6]  = '{2'b11, 32'h8000_0000, 32'd2,         32'h0000_0001};
        vecs[7]  = '{2'b00, 32'h1234_5678, 32'h10,        32'h2345_6780};
        vecs[8]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[9]  = '{2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};
        vecs[10] = '{2'b00, 32'hFFFF_FFFF, 32'd7,         32'hFFFF_FFF9};
        vecs[11] = '{2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFE};

        for (int i = 0; i < 8; i++) begin
            bp_a[i]   = 32'h0001_0003 + 32'(i);
            bp_b[i]   = 32'(257 * (i + 1));
            prod      = {32'd0, bp_a[i]} * {32'd0, bp_b[i]};
            bp_exp[i] = prod[31:0];
        end

        // Reset state
        #1;
        reset_n = 1'b0;
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_bm", 64'(out_bm), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Vector table: one op at a time, exact 4-cycle latency
        cdb_grant = 1'b1;
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].func, vecs[i].rs1, vecs[i].rs2, 6'(10 + i), 4'b0000);
            for (int c = 0; c <= 4; c++) begin
                #1;
                if (c == 3) chk("lat_early", 64'(out_valid), 64'd0);
                if (c == 4) begin
                    chk("vec_valid", 64'(out_valid), 64'd1);
                    chk("vec_result", 64'(out_result), 64'(vecs[i].exp));
                    chk("vec_tag", 64'(out_tag), 64'(10 + i));
                    chk("vec_bm", 64'(out_bm), 64'd0);
                end
                tick();
            end
        end

        // Backpressure: grant low, 8 ops offered, only 6 fit
        cdb_grant = 1'b0;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = (idx < 8);
            if (idx < 8) begin
                in_func = 2'b00; in_rs1 = bp_a[idx]; in_rs2 = bp_b[idx];
                in_tag = 6'(idx); in_bm = 4'b0000;
            end
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(bp_exp[idx]);
                idx++;
            end
            tick();
        end
        chk("bp_accepted", 64'(idx), 64'd6);
        in_valid = 1'b1;
        in_func = 2'b00; in_rs1 = bp_a[idx]; in_rs2 = bp_b[idx]; in_tag = 6'(idx);
        #1;
        chk("bp_ready_low", 64'(in_ready), 64'd0);
        chk("bp_head_valid", 64'(out_valid), 64'd1);
        cdb_grant = 1'b1;
        pops = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = (idx < 8);
            if (idx < 8) begin
                in_func = 2'b00; in_rs1 = bp_a[idx]; in_rs2 = bp_b[idx];
                in_tag = 6'(idx); in_bm = 4'b0000;
            end
            #1;
            if (in_valid && in_ready) idx++;
            if (c < 8) chk("bp_stream_valid", 64'(out_valid), 64'd1);
            if (out_valid) begin
                if (exp_q.size() > 0) chk("bp_result", 64'(out_result), 64'(exp_q.pop_front()));
                chk("bp_tag", 64'(out_tag), 64'(pops));
                pops++;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("bp_total", 64'(pops), 64'd8);
        chk("bp_all_accepted", 64'(idx), 64'd8);

        // Branch resolve: mispredict then correct prediction
        run_branch(1'b1);
        run_branch(1'b0);

        // Queue head squash while granted
        cdb_grant = 1'b0;
        issue(2'b00, 32'd9, 32'd9, 6'd30, 4'b0101);
        issue(2'b00, 32'd4, 32'd4, 6'd31, 4'b0000);
        repeat (6) tick();
        b_resolve = 4'b0001;
        b_mispred = 1'b0;
        #1;
        chk("sq_head_valid", 64'(out_valid), 64'd1);
        chk("sq_head_tag", 64'(out_tag), 64'd30);
        chk("sq_bm_comb", 64'(out_bm), 64'b0100);
        tick();
        b_resolve = 4'b0000;
        #1;
        chk("sq_bm_reg", 64'(out_bm), 64'b0100);
        tick();
        b_resolve = 4'b0100;
        b_mispred = 1'b1;
        cdb_grant = 1'b1;
        #1;
        chk("sq_kill_valid", 64'(out_valid), 64'd0);
        tick();
        b_resolve = 4'b0000;
        b_mispred = 1'b0;
        #1;
        chk("sq_next_valid", 64'(out_valid), 64'd1);
        chk("sq_next_tag", 64'(out_tag), 64'd31);
        chk("sq_next_result", 64'(out_result), 64'd16);
        tick();
        #1;
        chk("sq_drained_busy", 64'(busy), 64'd0);
        tick();

        // Flush with three in flight plus one offered
        cdb_grant = 1'b1;
        issue(2'b00, 32'd2, 32'd3, 6'd40, 4'b0000);
        issue(2'b00, 32'd2, 32'd4, 6'd41, 4'b0000);
        issue(2'b00, 32'd2, 32'd5, 6'd42, 4'b0000);
        in_valid = 1'b1;
        in_rs1 = 32'd2; in_rs2 = 32'd6; in_tag = 6'd43;
        flush = 1'b1;
        #1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_busy", 64'(busy), 64'd0);
        clear_got();
        collect(10);
        chk("flush_no_output", 64'(got_tag.size()), 64'd0);

        // Reset asserted mid-operation
        cdb_grant = 1'b0;
        for (int i = 0; i < 6; i++) begin
            issue(2'b00, 32'd3, 32'(i), 6'(50 + i), 4'b0000);
        end
        repeat (4) tick();
        #1;
        chk("mid_pre_valid", 64'(out_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        @(posedge clock);
        @(posedge clock);
        #3;
        reset_n = 1'b1;
        tick();
        #1;
        chk("mid_rel_ready", 64'(in_ready), 64'd1);
        cdb_grant = 1'b1;
        clear_got();
        collect(10);
        chk("mid_no_output", 64'(got_tag.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
